// File: rtl/fetch_unit.sv
// fetch_unit: program counter sequencer with a small branch-target LUT.
// IDLE waits for Start, RUN steps or branches the PC each cycle, DONE parks
// after a Halt until the next Start. CycleCount measures time spent in RUN.
module fetch_unit #(
  parameter int PC_W   = 10,
  parameter int LUT_AW = 5
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              Start,
  input  logic [PC_W-1:0]   StartAddr,
  input  logic              Halt,
  input  logic              branch_en,
  input  logic              ZERO,
  input  logic [LUT_AW-1:0] Target_idx,
  input  logic              lut_we,
  input  logic [LUT_AW-1:0] lut_addr,
  input  logic [PC_W-1:0]   lut_data,
  output logic [PC_W-1:0]   PC,
  output logic              Running,
  output logic              Done,
  output logic [15:0]       CycleCount
);

  localparam int LUT_DEPTH = 1 << LUT_AW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [PC_W-1:0] lut [LUT_DEPTH];
  logic [PC_W-1:0] branch_target;
  logic            branch_taken;

  // Next sequential address; wraps silently at the top of the address space.
  function automatic logic [PC_W-1:0] pc_step(input logic [PC_W-1:0] pc);
    pc_step = pc + {{(PC_W-1){1'b0}}, 1'b1};
  endfunction

  // Cycle counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] cnt);
    if (cnt == 16'hFFFF) sat_inc16 = cnt;
    else                 sat_inc16 = cnt + 16'd1;
  endfunction

  // Branch resolution reads the table combinationally, so a write landing on
  // the same edge is only seen by later branches.
  assign branch_target = lut[Target_idx];
  assign branch_taken  = branch_en && ZERO;

  assign Running = (state == RUN);
  assign Done    = (state == DONE);

  // Branch-target table: cleared by reset, otherwise written whenever enabled.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      for (int i = 0; i < LUT_DEPTH; i++) lut[i] <= '0;
    end else if (lut_we) begin
      lut[lut_addr] <= lut_data;
    end
  end

  // Sequencer FSM: owns state, PC and the RUN cycle counter.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state      <= IDLE;
      PC         <= '0;
      CycleCount <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (Start) begin
            state      <= RUN;
            PC         <= StartAddr;
            CycleCount <= '0;
          end
        end
        RUN: begin
          CycleCount <= sat_inc16(CycleCount);
          if (Halt)              state <= DONE;
          else if (branch_taken) PC    <= branch_target;
          else                   PC    <= pc_step(PC);
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vectors for fetch_unit with hand-computed expectations.
module tb_fetch_unit;

  localparam int PC_W   = 10;
  localparam int LUT_AW = 5;

  logic              CLK;
  logic              Reset;
  logic              Start;
  logic [PC_W-1:0]   StartAddr;
  logic              Halt;
  logic              branch_en;
  logic              ZERO;
  logic [LUT_AW-1:0] Target_idx;
  logic              lut_we;
  logic [LUT_AW-1:0] lut_addr;
  logic [PC_W-1:0]   lut_data;
  logic [PC_W-1:0]   PC;
  logic              Running;
  logic              Done;
  logic [15:0]       CycleCount;

  int n_cmp;
  int n_bad;

  fetch_unit #(.PC_W(PC_W), .LUT_AW(LUT_AW)) dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
    .Halt(Halt), .branch_en(branch_en), .ZERO(ZERO), .Target_idx(Target_idx),
    .lut_we(lut_we), .lut_addr(lut_addr), .lut_data(lut_data),
    .PC(PC), .Running(Running), .Done(Done), .CycleCount(CycleCount)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [PC_W-1:0] pc,
                           input logic run, input logic dn, input logic [15:0] cc);
    chk_val({tag, ".pc"}, 32'(PC), 32'(pc));
    chk_val({tag, ".run"}, 32'(Running), 32'(run));
    chk_val({tag, ".done"}, 32'(Done), 32'(dn));
    chk_val({tag, ".cc"}, 32'(CycleCount), 32'(cc));
  endtask

  task automatic do_start(input logic [PC_W-1:0] addr);
    Start = 1'b1; StartAddr = addr;
    tick();
    Start = 1'b0;
  endtask

  task automatic do_halt();
    Halt = 1'b1;
    tick();
    Halt = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    Reset = 1'b1; Start = 1'b0; StartAddr = '0; Halt = 1'b0;
    branch_en = 1'b0; ZERO = 1'b0; Target_idx = '0;
    lut_we = 1'b0; lut_addr = '0; lut_data = '0;
    tick(); tick();
    Reset = 1'b0;
    chk_state("reset", 10'h000, 1'b0, 1'b0, 16'd0);

    // LUT[3] = 0x200 while idle; idle ignores halt/branch inputs
    lut_we = 1'b1; lut_addr = 5'd3; lut_data = 10'h200;
    Halt = 1'b1; branch_en = 1'b1; ZERO = 1'b1; Target_idx = 5'd3;
    tick();
    lut_we = 1'b0; Halt = 1'b0; branch_en = 1'b0; ZERO = 1'b0;
    chk_state("idle_ignore", 10'h000, 1'b0, 1'b0, 16'd0);

    // Start at 0x010, then three sequential steps
    do_start(10'h010);
    chk_state("start", 10'h010, 1'b1, 1'b0, 16'd0);
    tick(); tick(); tick();
    chk_state("step3", 10'h013, 1'b1, 1'b0, 16'd3);

    // Start ignored while running
    Start = 1'b1; StartAddr = 10'h100;
    tick();
    Start = 1'b0;
    chk_state("start_in_run", 10'h014, 1'b1, 1'b0, 16'd4);

    // Halt counts its own edge; DONE holds PC and count
    do_halt();
    chk_state("halt", 10'h014, 1'b0, 1'b1, 16'd5);
    tick();
    chk_state("done_hold", 10'h014, 1'b0, 1'b1, 16'd5);

    // Taken branch at 0x020 via LUT[3]
    do_start(10'h020);
    branch_en = 1'b1; ZERO = 1'b1; Target_idx = 5'd3;
    tick();
    branch_en = 1'b0; ZERO = 1'b0;
    chk_state("br_taken", 10'h200, 1'b1, 1'b0, 16'd1);

    // Not-taken branch at 0x020
    do_halt();
    do_start(10'h020);
    branch_en = 1'b1; ZERO = 1'b0; Target_idx = 5'd3;
    tick();
    branch_en = 1'b0;
    chk_val("br_not_taken.pc", 32'(PC), 32'h021);

    // Halt beats a taken branch at 0x050; restart clears count
    do_halt();
    do_start(10'h050);
    Halt = 1'b1; branch_en = 1'b1; ZERO = 1'b1; Target_idx = 5'd3;
    tick();
    Halt = 1'b0; branch_en = 1'b0; ZERO = 1'b0;
    chk_state("halt_prio", 10'h050, 1'b0, 1'b1, 16'd1);
    do_start(10'h060);
    chk_state("restart", 10'h060, 1'b1, 1'b0, 16'd0);

    // PC wrap at top of address space
    do_halt();
    do_start(10'h3FF);
    chk_val("wrap0.pc", 32'(PC), 32'h3FF);
    tick();
    chk_val("wrap1.pc", 32'(PC), 32'h000);

    // Same-edge LUT write does not affect the branch reading that entry
    lut_we = 1'b1; lut_addr = 5'd3; lut_data = 10'h111;
    branch_en = 1'b1; ZERO = 1'b1; Target_idx = 5'd3;
    tick();
    lut_we = 1'b0;
    chk_val("wr_same_edge.pc", 32'(PC), 32'h200);
    tick();
    branch_en = 1'b0; ZERO = 1'b0;
    chk_val("wr_later.pc", 32'(PC), 32'h111);

    // Reach 0x123 through LUT[5], then reset mid-run
    lut_we = 1'b1; lut_addr = 5'd5; lut_data = 10'h123;
    tick();
    lut_we = 1'b0;
    chk_val("pre_br5.pc", 32'(PC), 32'h112);
    branch_en = 1'b1; ZERO = 1'b1; Target_idx = 5'd5;
    tick();
    branch_en = 1'b0; ZERO = 1'b0;
    chk_val("br5.pc", 32'(PC), 32'h123);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk_state("reset_run", 10'h000, 1'b0, 1'b0, 16'd0);
    tick();
    chk_val("reset_no_done", 32'(Done), 32'h0);

    // LUT cleared by reset
    do_start(10'h040);
    branch_en = 1'b1; ZERO = 1'b1; Target_idx = 5'd3;
    tick();
    branch_en = 1'b0; ZERO = 1'b0;
    chk_val("lut_cleared.pc", 32'(PC), 32'h000);

    // Reset wins over Start and lut_we on the same edge
    Reset = 1'b1; Start = 1'b1; StartAddr = 10'h077;
    lut_we = 1'b1; lut_addr = 5'd7; lut_data = 10'h2AA;
    tick();
    Reset = 1'b0; Start = 1'b0; lut_we = 1'b0;
    chk_state("reset_prio", 10'h000, 1'b0, 1'b0, 16'd0);
    do_start(10'h010);
    branch_en = 1'b1; ZERO = 1'b1; Target_idx = 5'd7;
    tick();
    branch_en = 1'b0; ZERO = 1'b0;
    chk_val("reset_prio_lut.pc", 32'(PC), 32'h000);

    // Cycle counter saturation
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    do_start(10'h000);
    repeat (65534) tick();
    chk_val("cc_65534", 32'(CycleCount), 32'd65534);
    tick();
    chk_val("cc_65535", 32'(CycleCount), 32'hFFFF);
    tick(); tick(); tick();
    chk_val("cc_sat", 32'(CycleCount), 32'hFFFF);
    chk_val("cc_sat.pc", 32'(PC), 32'h002);
    do_halt();
    chk_state("cc_sat_halt", 10'h002, 1'b0, 1'b1, 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The module SHALL have parameter PC_W, default 10, program counter width in bits.
REQ-002 The module SHALL have parameter LUT_AW, default 5, branch-target LUT address width (2**LUT_AW entries).
REQ-003 The module SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-005 The module SHALL have port Start, input, 1, begin program execution at StartAddr.
REQ-006 The module SHALL have port StartAddr, input, PC_W, first instruction address.
REQ-007 The module SHALL have port Halt, input, 1, current instruction is the halt opcode.
REQ-008 The module SHALL have port branch_en, input, 1, current instruction is a conditional branch, from the control decoder.
REQ-009 The module SHALL have port ZERO, input, 1, ALU result equals zero, the branch condition.
REQ-010 The module SHALL have port Target_idx, input, LUT_AW, branch-target LUT index (Instruction[4:0]).
REQ-011 The module SHALL have port lut_we, input, 1, LUT write enable.
REQ-012 The module SHALL have port lut_addr, input, LUT_AW, LUT write address.
REQ-013 The module SHALL have port lut_data, input, PC_W, LUT write data (absolute target).
REQ-014 The module SHALL have port PC, output, PC_W, instruction ROM address.
REQ-015 The module SHALL have port Running, output, 1, high while in RUN.
REQ-016 The module SHALL have port Done, output, 1, high while in DONE.
REQ-017 The module SHALL have port CycleCount, output, 16, number of cycles spent in RUN since the last accepted Start.

Function
REQ-018 The FSM SHALL have states IDLE, RUN, DONE; Running = (state==RUN), Done = (state==DONE), both registered-state decodes.
REQ-019 In IDLE or DONE, Start=1 SHALL load PC<=StartAddr, CycleCount<=0, state<=RUN at the same edge.
REQ-020 In IDLE or DONE with Start=0, PC and CycleCount SHALL hold; Halt, branch_en, ZERO and Target_idx SHALL be ignored.
REQ-021 In RUN, Start SHALL be ignored.
REQ-022 In RUN, per edge, priority order SHALL be: Halt -> state<=DONE, PC holds; else branch_en&&ZERO -> PC<=LUT[Target_idx]; else PC<=PC+1.
REQ-023 branch_en with ZERO=0 (not taken) SHALL advance PC<=PC+1.
REQ-024 PC+1 SHALL wrap modulo 2**PC_W (all-ones -> 0) with no flag or error.
REQ-025 CycleCount SHALL increment by 1 on every edge in RUN, including the Halt edge, and saturate at 0xFFFF.
REQ-026 LUT writes SHALL occur at the edge when lut_we=1, in any state.
REQ-027 A branch SHALL read the LUT combinationally; a same-cycle write to the same index SHALL NOT affect that branch, which uses the old entry.
REQ-028 PC SHALL change only as stated in REQ-019 and REQ-022; zero-cycle branch penalty, with the new PC visible the cycle after the branch instruction.

Reset
REQ-029 Reset=1 SHALL at the next edge set state=IDLE, PC=0, CycleCount=0, all LUT entries=0, hence Running=0 and Done=0.
REQ-030 Reset SHALL take priority over Start, Halt, branch and lut_we in the same cycle; reset mid-RUN SHALL abandon execution with no Done pulse.

Verification
REQ-031 Reset, then Start with StartAddr=0x010 -> next cycle PC=0x010, Running=1; after 3 idle cycles PC=0x013, CycleCount=3.
REQ-032 LUT[3]=0x200 written; in RUN at PC=0x020 with branch_en=1, ZERO=1, Target_idx=3 -> PC=0x200; same with ZERO=0 -> PC=0x021.
REQ-033 Halt=1 and branch_en=1, ZERO=1 in the same cycle at PC=0x050 -> DONE, PC stays 0x050, Done=1; Start then restarts at StartAddr with CycleCount=0.
REQ-034 Start at StartAddr=0x3FF, no branch -> PC=0x3FF then 0x000.
REQ-035 lut_we to index 3 (0x111) in the same cycle as a taken branch via index 3 (old 0x200) -> PC=0x200; a later branch via index 3 -> 0x111.
REQ-036 Reset asserted in RUN at PC=0x123 -> next cycle PC=0, IDLE, Done=0, LUT[3]=0; run >65535 cycles -> CycleCount holds 0xFFFF.
